// File: rtl/pma_table_writer.sv
// +----------------------------------------------------------------------------+
// | pma_table_writer: shadow/active PMA table with validated atomic commit.    |
// | Optional feature macro: PMA_LOCK_EN (per-entry lock bits).                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module pma_table_writer #(
  parameter int                  ENTRIES    = 8,
  parameter int                  ATTR_LEN   = 8,
  parameter logic [ATTR_LEN-1:0] RESET_ATTR = 8'h07
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         Wr_Valid,
  output logic                         Wr_Ready,
  input  logic [3:0]                   Wr_Index,
  input  logic [1:0]                   Wr_Field,
  input  logic [63:0]                  Wr_Data,
  output logic                         Wr_Resp_Valid,
  output logic                         Wr_Resp_Err,
  output logic                         Table_Busy,
  output logic [64*ENTRIES-1:0]        PMA_Base_Bus,
  output logic [64*ENTRIES-1:0]        PMA_Size_Bus,
  output logic [ATTR_LEN*ENTRIES-1:0]  PMA_Attr_Bus
);

  localparam int          IDXW          = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam logic [4:0]  c_ENTRIES     = 5'(ENTRIES);
  localparam logic [63:0] c_ONES        = {64{1'b1}};
  localparam logic [63:0] c_ATTR_MASK   = (64'd1 << ATTR_LEN) - 64'd1;

  localparam logic [1:0]  F_BASE = 2'd0;
  localparam logic [1:0]  F_SIZE = 2'd1;
  localparam logic [1:0]  F_ATTR = 2'd2;
  localparam logic [1:0]  F_CTRL = 2'd3;

  localparam logic [1:0]  S_IDLE   = 2'd0;
  localparam logic [1:0]  S_COMMIT = 2'd1;
  localparam logic [1:0]  S_RESP   = 2'd2;

  logic [1:0]          r_state;
  logic [1:0]          w_next_state;
  logic                r_err;

  logic [63:0]         r_sh_base  [ENTRIES];
  logic [63:0]         r_sh_size  [ENTRIES];
  logic [ATTR_LEN-1:0] r_sh_attr  [ENTRIES];
  logic [63:0]         r_act_base [ENTRIES];
  logic [63:0]         r_act_size [ENTRIES];
  logic [ATTR_LEN-1:0] r_act_attr [ENTRIES];

`ifdef PMA_LOCK_EN
  logic [ENTRIES-1:0]  r_sh_lock;
  logic [ENTRIES-1:0]  r_act_lock;
`endif

  logic [IDXW-1:0]     w_idx;
  logic                w_idx_ok;
  logic                w_hs;
  logic                w_req_err;
  logic                w_misaligned;

  assign w_idx    = Wr_Index[IDXW-1:0];
  assign w_idx_ok = ({1'b0, Wr_Index} < c_ENTRIES);
  assign w_hs     = Wr_Valid && (r_state == S_IDLE);

  always_comb begin
    w_req_err = 1'b0;
    if (Wr_Field == F_CTRL) begin
`ifdef PMA_LOCK_EN
      w_req_err = Wr_Data[1] && !w_idx_ok;
`endif
    end else begin
      if (!w_idx_ok)
        w_req_err = 1'b1;
      if ((Wr_Field == F_SIZE) && ((Wr_Data & (Wr_Data + 64'd1)) != 64'd0))
        w_req_err = 1'b1;
      if ((Wr_Field == F_ATTR) && ((Wr_Data & ~c_ATTR_MASK) != 64'd0))
        w_req_err = 1'b1;
`ifdef PMA_LOCK_EN
      if (w_idx_ok && r_act_lock[w_idx])
        w_req_err = 1'b1;
`endif
    end
  end

  // A region whose base has bits inside its size mask would match oddly in the checker.
  always_comb begin
    w_misaligned = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if ((r_sh_base[i] & r_sh_size[i]) != 64'd0)
        w_misaligned = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_hs)
          w_next_state = ((Wr_Field == F_CTRL) && Wr_Data[0]) ? S_COMMIT : S_RESP;
      end
      S_COMMIT: w_next_state = S_RESP;
      S_RESP:   w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    Wr_Ready      = (r_state == S_IDLE);
    Table_Busy    = (r_state == S_COMMIT);
    Wr_Resp_Valid = (r_state == S_RESP);
    Wr_Resp_Err   = (r_state == S_RESP) && r_err;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_sh_base[i]  <= 64'd0;
        r_sh_size[i]  <= (i == 0) ? c_ONES : 64'd0;
        r_sh_attr[i]  <= (i == 0) ? RESET_ATTR : '0;
        r_act_base[i] <= 64'd0;
        r_act_size[i] <= (i == 0) ? c_ONES : 64'd0;
        r_act_attr[i] <= (i == 0) ? RESET_ATTR : '0;
      end
`ifdef PMA_LOCK_EN
      r_sh_lock  <= '0;
      r_act_lock <= '0;
`endif
    end else begin
      if (w_hs) begin
        r_err <= w_req_err;
        if (!w_req_err) begin
          case (Wr_Field)
            F_BASE: r_sh_base[w_idx] <= Wr_Data;
            F_SIZE: r_sh_size[w_idx] <= Wr_Data;
            F_ATTR: r_sh_attr[w_idx] <= Wr_Data[ATTR_LEN-1:0];
            default: begin
`ifdef PMA_LOCK_EN
              // Shadow lock lands before the COMMIT cycle, so lock+commit applies at once.
              if (Wr_Data[1])
                r_sh_lock[w_idx] <= 1'b1;
`endif
            end
          endcase
        end
      end
      if (r_state == S_COMMIT) begin
        r_err <= r_err || w_misaligned;
        if (!w_misaligned) begin
          for (int i = 0; i < ENTRIES; i++) begin
            r_act_base[i] <= r_sh_base[i];
            r_act_size[i] <= r_sh_size[i];
            r_act_attr[i] <= r_sh_attr[i];
          end
`ifdef PMA_LOCK_EN
          r_act_lock <= r_sh_lock;
`endif
        end
      end
    end
  end

  for (genvar g = 0; g < ENTRIES; g++) begin : g_flat
    assign PMA_Base_Bus[64*g +: 64]             = r_act_base[g];
    assign PMA_Size_Bus[64*g +: 64]             = r_act_size[g];
    assign PMA_Attr_Bus[ATTR_LEN*g +: ATTR_LEN] = r_act_attr[g];
  end

endmodule

`default_nettype wire

// File: tb/tb_pma_table_writer.sv
// +----------------------------------------------------------------------------+
// | tb_pma_table_writer: directed self-checking bench for pma_table_writer.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_pma_table_writer;

  localparam int N = 8;
  localparam int A = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           Wr_Valid;
  logic           Wr_Ready;
  logic [3:0]     Wr_Index;
  logic [1:0]     Wr_Field;
  logic [63:0]    Wr_Data;
  logic           Wr_Resp_Valid;
  logic           Wr_Resp_Err;
  logic           Table_Busy;
  logic [64*N-1:0] PMA_Base_Bus;
  logic [64*N-1:0] PMA_Size_Bus;
  logic [A*N-1:0]  PMA_Attr_Bus;

  int n_checks = 0;
  int n_fail   = 0;

  logic [64*N-1:0] e_rst_size;
  logic [A*N-1:0]  e_rst_attr;

  always #5 clk = ~clk;

  pma_table_writer dut (
    .clk           (clk),
    .reset         (reset),
    .Wr_Valid      (Wr_Valid),
    .Wr_Ready      (Wr_Ready),
    .Wr_Index      (Wr_Index),
    .Wr_Field      (Wr_Field),
    .Wr_Data       (Wr_Data),
    .Wr_Resp_Valid (Wr_Resp_Valid),
    .Wr_Resp_Err   (Wr_Resp_Err),
    .Table_Busy    (Table_Busy),
    .PMA_Base_Bus  (PMA_Base_Bus),
    .PMA_Size_Bus  (PMA_Size_Bus),
    .PMA_Attr_Bus  (PMA_Attr_Bus)
  );

  // Issues one request; returns error bit and cycles from handshake to response (-1 on timeout).
  task automatic send(input logic [3:0] idx, input logic [1:0] fld, input logic [63:0] d,
                      output logic err, output int lat);
    int waitc;
    waitc    = 0;
    Wr_Index = idx;
    Wr_Field = fld;
    Wr_Data  = d;
    Wr_Valid = 1'b1;
    while (!Wr_Ready && waitc < 20) begin
      @(posedge clk); #1;
      waitc++;
    end
    @(posedge clk); #1;
    Wr_Valid = 1'b0;
    lat = 1;
    while (!Wr_Resp_Valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    err = Wr_Resp_Err;
    if (!Wr_Resp_Valid) lat = -1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    Wr_Valid = 1'b0; Wr_Index = '0; Wr_Field = '0; Wr_Data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (PMA_Base_Bus !== '0) begin n_fail++;
      $display("FAIL rst_base got %h want 0", PMA_Base_Bus); end
    n_checks++;
    if (PMA_Size_Bus !== e_rst_size) begin n_fail++;
      $display("FAIL rst_size got %h want %h", PMA_Size_Bus, e_rst_size); end
    n_checks++;
    if (PMA_Attr_Bus !== e_rst_attr) begin n_fail++;
      $display("FAIL rst_attr got %h want %h", PMA_Attr_Bus, e_rst_attr); end
    n_checks++;
    if ({Wr_Ready, Table_Busy, Wr_Resp_Valid, Wr_Resp_Err} !== 4'b1000) begin n_fail++;
      $display("FAIL rst_ctrl got %b want 1000", {Wr_Ready, Table_Busy, Wr_Resp_Valid, Wr_Resp_Err}); end
  endtask

  task automatic test_write_commit();
    logic err; int lat;
    send(4'd1, 2'd0, 64'h8000_0000, err, lat);
    n_checks++;
    if (err !== 1'b0 || lat != 1) begin n_fail++;
      $display("FAIL wr_base err=%b lat=%0d want err=0 lat=1", err, lat); end
    n_checks++;
    if (Wr_Ready !== 1'b1) begin n_fail++;
      $display("FAIL ready_T2 got %b want 1", Wr_Ready); end
    send(4'd1, 2'd1, 64'hFFFF, err, lat);
    n_checks++;
    if (err !== 1'b0 || lat != 1) begin n_fail++;
      $display("FAIL wr_size err=%b lat=%0d want err=0 lat=1", err, lat); end
    send(4'd1, 2'd2, 64'h03, err, lat);
    n_checks++;
    if (err !== 1'b0 || lat != 1) begin n_fail++;
      $display("FAIL wr_attr err=%b lat=%0d want err=0 lat=1", err, lat); end
    n_checks++;
    if (PMA_Base_Bus[64*1 +: 64] !== 64'd0) begin n_fail++;
      $display("FAIL shadow_leak got %h want 0", PMA_Base_Bus[64*1 +: 64]); end
    // Commit, checked cycle by cycle.
    Wr_Index = 4'd0; Wr_Field = 2'd3; Wr_Data = 64'h1; Wr_Valid = 1'b1;
    @(posedge clk); #1;
    Wr_Valid = 1'b0;
    n_checks++;
    if ({Table_Busy, Wr_Resp_Valid, Wr_Ready} !== 3'b100) begin n_fail++;
      $display("FAIL commit_T1 busy/resp/rdy got %b want 100", {Table_Busy, Wr_Resp_Valid, Wr_Ready}); end
    n_checks++;
    if (PMA_Base_Bus[64*1 +: 64] !== 64'd0) begin n_fail++;
      $display("FAIL commit_T1_base got %h want 0", PMA_Base_Bus[64*1 +: 64]); end
    @(posedge clk); #1;
    n_checks++;
    if ({Table_Busy, Wr_Resp_Valid, Wr_Resp_Err, Wr_Ready} !== 4'b0100) begin n_fail++;
      $display("FAIL commit_T2 busy/resp/err/rdy got %b want 0100",
               {Table_Busy, Wr_Resp_Valid, Wr_Resp_Err, Wr_Ready}); end
    n_checks++;
    if (PMA_Base_Bus[64*1 +: 64] !== 64'h8000_0000 || PMA_Size_Bus[64*1 +: 64] !== 64'hFFFF ||
        PMA_Attr_Bus[A*1 +: A] !== 8'h03) begin n_fail++;
      $display("FAIL commit_e1 got %h/%h/%h want 80000000/ffff/03", PMA_Base_Bus[64*1 +: 64],
               PMA_Size_Bus[64*1 +: 64], PMA_Attr_Bus[A*1 +: A]); end
    @(posedge clk); #1;
    n_checks++;
    if ({Wr_Ready, Wr_Resp_Valid} !== 2'b10) begin n_fail++;
      $display("FAIL commit_T3 rdy/resp got %b want 10", {Wr_Ready, Wr_Resp_Valid}); end
  endtask

  task automatic test_errors();
    logic err; int lat;
    send(4'd2, 2'd1, 64'h0F0F, err, lat);
    n_checks++;
    if (err !== 1'b1 || lat != 1) begin n_fail++;
      $display("FAIL size_noncontig err=%b lat=%0d want err=1 lat=1", err, lat); end
    send(4'd4, 2'd2, 64'h100, err, lat);
    n_checks++;
    if (err !== 1'b1) begin n_fail++;
      $display("FAIL attr_wide err=%b want 1", err); end
    send(4'd3, 2'd0, 64'h1000, err, lat);
    send(4'd3, 2'd1, 64'h1FFF, err, lat);
    n_checks++;
    if (err !== 1'b0) begin n_fail++;
      $display("FAIL size_1fff err=%b want 0", err); end
    send(4'd0, 2'd3, 64'h1, err, lat);
    n_checks++;
    if (err !== 1'b1 || lat != 2) begin n_fail++;
      $display("FAIL misaligned_commit err=%b lat=%0d want err=1 lat=2", err, lat); end
    n_checks++;
    if (PMA_Base_Bus[64*3 +: 64] !== 64'd0 || PMA_Size_Bus[64*3 +: 64] !== 64'd0 ||
        PMA_Base_Bus[64*1 +: 64] !== 64'h8000_0000) begin n_fail++;
      $display("FAIL abort_unchanged e3 %h/%h e1 %h want 0/0/80000000", PMA_Base_Bus[64*3 +: 64],
               PMA_Size_Bus[64*3 +: 64], PMA_Base_Bus[64*1 +: 64]); end
    send(4'd3, 2'd0, 64'h0, err, lat);
    send(4'd0, 2'd3, 64'h1, err, lat);
    n_checks++;
    if (err !== 1'b0) begin n_fail++;
      $display("FAIL fixed_commit err=%b want 0", err); end
    n_checks++;
    if (PMA_Size_Bus[64*2 +: 64] !== 64'd0 || PMA_Size_Bus[64*3 +: 64] !== 64'h1FFF ||
        PMA_Attr_Bus[A*4 +: A] !== 8'h00) begin n_fail++;
      $display("FAIL fixed_values s2=%h s3=%h a4=%h want 0/1fff/00", PMA_Size_Bus[64*2 +: 64],
               PMA_Size_Bus[64*3 +: 64], PMA_Attr_Bus[A*4 +: A]); end
  endtask

  task automatic test_index_and_noop();
    logic err; int lat;
    send(4'(N), 2'd0, 64'h40, err, lat);
    n_checks++;
    if (err !== 1'b1) begin n_fail++;
      $display("FAIL index_oob err=%b want 1", err); end
    send(4'd15, 2'd1, 64'hF, err, lat);
    n_checks++;
    if (err !== 1'b1) begin n_fail++;
      $display("FAIL index_15 err=%b want 1", err); end
    send(4'd0, 2'd3, 64'h0, err, lat);
    n_checks++;
    if (err !== 1'b0 || lat != 1) begin n_fail++;
      $display("FAIL ctrl_noop err=%b lat=%0d want err=0 lat=1", err, lat); end
  endtask

  task automatic test_back_to_back();
    Wr_Index = 4'd5; Wr_Field = 2'd2; Wr_Data = 64'h05; Wr_Valid = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({Wr_Resp_Valid, Wr_Ready} !== 2'b10) begin n_fail++;
      $display("FAIL hold_T1 resp/rdy got %b want 10", {Wr_Resp_Valid, Wr_Ready}); end
    @(posedge clk); #1;
    n_checks++;
    if ({Wr_Resp_Valid, Wr_Ready} !== 2'b01) begin n_fail++;
      $display("FAIL hold_T2 resp/rdy got %b want 01", {Wr_Resp_Valid, Wr_Ready}); end
    @(posedge clk); #1;
    Wr_Valid = 1'b0;
    n_checks++;
    if ({Wr_Resp_Valid, Wr_Ready} !== 2'b10) begin n_fail++;
      $display("FAIL hold_T3 resp/rdy got %b want 10", {Wr_Resp_Valid, Wr_Ready}); end
    @(posedge clk); #1;
    n_checks++;
    if ({Wr_Resp_Valid, Wr_Ready} !== 2'b01) begin n_fail++;
      $display("FAIL hold_T4 resp/rdy got %b want 01", {Wr_Resp_Valid, Wr_Ready}); end
  endtask

  task automatic test_reset_mid_commit();
    logic err; int lat; int resp_seen;
    send(4'd6, 2'd0, 64'h100, err, lat);
    send(4'd6, 2'd1, 64'hFF, err, lat);
    Wr_Index = 4'd0; Wr_Field = 2'd3; Wr_Data = 64'h1; Wr_Valid = 1'b1;
    @(posedge clk); #1;
    Wr_Valid = 1'b0;
    n_checks++;
    if (Table_Busy !== 1'b1) begin n_fail++;
      $display("FAIL midcommit_busy got %b want 1", Table_Busy); end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({Table_Busy, Wr_Resp_Valid, Wr_Ready} !== 3'b001) begin n_fail++;
      $display("FAIL async_rst busy/resp/rdy got %b want 001", {Table_Busy, Wr_Resp_Valid, Wr_Ready}); end
    @(posedge clk); #1;
    reset = 1'b0;
    resp_seen = 0;
    repeat (3) begin
      if (Wr_Resp_Valid) resp_seen++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (resp_seen != 0) begin n_fail++;
      $display("FAIL rst_no_resp got %0d responses want 0", resp_seen); end
    n_checks++;
    if (PMA_Base_Bus !== '0 || PMA_Size_Bus !== e_rst_size || PMA_Attr_Bus !== e_rst_attr) begin n_fail++;
      $display("FAIL rst_table got base %h size %h attr %h want reset table", PMA_Base_Bus,
               PMA_Size_Bus, PMA_Attr_Bus); end
    send(4'd0, 2'd3, 64'h1, err, lat);
    n_checks++;
    if (err !== 1'b0 || PMA_Base_Bus[64*6 +: 64] !== 64'd0 || PMA_Size_Bus[64*6 +: 64] !== 64'd0) begin n_fail++;
      $display("FAIL rst_shadow err=%b e6 %h/%h want 0/0/0", err, PMA_Base_Bus[64*6 +: 64],
               PMA_Size_Bus[64*6 +: 64]); end
  endtask

  task automatic test_lock();
    logic err; int lat; logic e_err; logic [63:0] e_base;
`ifdef PMA_LOCK_EN
    e_err = 1'b1; e_base = 64'd0;
`else
    e_err = 1'b0; e_base = 64'h4000;
`endif
    send(4'd1, 2'd3, 64'h3, err, lat);
    n_checks++;
    if (err !== 1'b0 || lat != 2) begin n_fail++;
      $display("FAIL lock_commit err=%b lat=%0d want err=0 lat=2", err, lat); end
    send(4'd1, 2'd0, 64'h4000, err, lat);
    n_checks++;
    if (err !== e_err) begin n_fail++;
      $display("FAIL locked_write err=%b want %b", err, e_err); end
    send(4'd2, 2'd0, 64'h0, err, lat);
    n_checks++;
    if (err !== 1'b0) begin n_fail++;
      $display("FAIL unlocked_write err=%b want 0", err); end
    send(4'd0, 2'd3, 64'h1, err, lat);
    n_checks++;
    if (err !== 1'b0 || PMA_Base_Bus[64*1 +: 64] !== e_base) begin n_fail++;
      $display("FAIL lock_base err=%b base %h want 0/%h", err, PMA_Base_Bus[64*1 +: 64], e_base); end
  endtask

  initial begin
    e_rst_size = '0;
    e_rst_size[63:0] = {64{1'b1}};
    e_rst_attr = '0;
    e_rst_attr[7:0] = 8'h07;
    test_reset();
    test_write_commit();
    test_errors();
    test_index_and_noop();
    test_back_to_back();
    test_reset_mid_commit();
    test_lock();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
